// File: rtl/reg_native_arb_pkg.sv
// reg_native_arb_pkg: shared types and constants for the reg_native_if arbiter.
//   arb_state_e        - arbiter FSM state (IDLE, WAIT)
//   ARB_TIMEOUT_RDATA  - read data returned to a master whose transaction timed out
//   ARB_TIMEOUT_CYCLES - default WAIT-state cycle limit
package reg_native_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } arb_state_e;

    localparam logic [31:0] ARB_TIMEOUT_RDATA  = 32'hDEAD_DEAD;
    localparam int unsigned ARB_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/reg_native_rr_pick.sv
// reg_native_rr_pick: combinational round-robin picker.
// Searches the pending vector starting one index above last_gnt, wrapping modulo NUM_MST.
// Ports:
//   pending  in  NUM_MST  request bits to choose from
//   last_gnt in  GID_W    index of the previous winner
//   any_vld  out 1        at least one pending bit is set
//   winner   out GID_W    first pending index after last_gnt (0 when none)
module reg_native_rr_pick #(
    parameter int unsigned NUM_MST = 2,
    localparam int unsigned GID_W = (NUM_MST > 1) ? $clog2(NUM_MST) : 1
) (
    input  logic [NUM_MST-1:0] pending,
    input  logic [GID_W-1:0]   last_gnt,
    output logic               any_vld,
    output logic [GID_W-1:0]   winner
);

    always_comb begin
        int unsigned idx;
        any_vld = 1'b0;
        winner  = '0;
        idx     = 0;
        // k = NUM_MST lands back on last_gnt, so it has the lowest priority
        for (int unsigned k = 1; k <= NUM_MST; k++) begin
            idx = (32'(last_gnt) + k) % NUM_MST;
            if (!any_vld && pending[GID_W'(idx)]) begin
                any_vld = 1'b1;
                winner  = GID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/reg_native_arb.sv
// reg_native_arb: shares one downstream reg_native_if slave between NUM_MST masters.
// Each master may have one outstanding request; requests are latched per master, granted
// round-robin, issued downstream as a one-cycle req_vld, and completed back to the winner.
// Optional feature: define REG_NATIVE_ARB_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_CYCLES cycles, answering the master with ARB_TIMEOUT_RDATA and a timeout pulse.
// Ports:
//   fsm_clk, fsm_rst                       clock, synchronous active-high reset
//   m_req_vld/m_wr_en/m_rd_en/m_addr/m_wr_data  upstream requests (slice i = master i)
//   m_ack_vld, m_rd_data                   upstream completion pulse and shared read data
//   req_vld/wr_en/rd_en/addr/wr_data       downstream request
//   ack_vld, rd_data                       downstream completion
//   busy, grant_id, timeout                status
module reg_native_arb
    import reg_native_arb_pkg::*;
#(
    parameter int unsigned NUM_MST        = 2,
    parameter int unsigned ADDR_WIDTH     = 64,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES,
    localparam int unsigned GID_W = (NUM_MST > 1) ? $clog2(NUM_MST) : 1
) (
    input  logic                          fsm_clk,
    input  logic                          fsm_rst,
    input  logic [NUM_MST-1:0]            m_req_vld,
    input  logic [NUM_MST-1:0]            m_wr_en,
    input  logic [NUM_MST-1:0]            m_rd_en,
    input  logic [NUM_MST*ADDR_WIDTH-1:0] m_addr,
    input  logic [NUM_MST*DATA_WIDTH-1:0] m_wr_data,
    output logic [NUM_MST-1:0]            m_ack_vld,
    output logic [DATA_WIDTH-1:0]         m_rd_data,
    output logic                          req_vld,
    output logic                          wr_en,
    output logic                          rd_en,
    output logic [ADDR_WIDTH-1:0]         addr,
    output logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          ack_vld,
    input  logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          busy,
    output logic [GID_W-1:0]              grant_id,
    output logic                          timeout
);

    arb_state_e state_q, state_d;

    logic [NUM_MST-1:0]    pending_q, pending_d;
    logic [NUM_MST-1:0]    buf_wr_q, buf_rd_q;
    logic [ADDR_WIDTH-1:0] buf_addr_q  [NUM_MST];
    logic [DATA_WIDTH-1:0] buf_wdata_q [NUM_MST];

    logic [GID_W-1:0]      last_gnt_q, last_gnt_d, gnt_q, gnt_d;
    logic                  req_vld_q, req_vld_d, wr_en_q, wr_en_d, rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [NUM_MST-1:0]    ack_q, ack_d;
    logic                  tmo_q, tmo_d;

    logic             any_vld;
    logic [GID_W-1:0] winner;
    logic             tmo_hit, done;

    reg_native_rr_pick #(
        .NUM_MST(NUM_MST)
    ) u_pick (
        .pending (pending_q),
        .last_gnt(last_gnt_q),
        .any_vld (any_vld),
        .winner  (winner)
    );

`ifdef REG_NATIVE_ARB_TIMEOUT_EN
    logic [31:0] wait_cnt_q, wait_cnt_d;

    // A real ack in the limit cycle wins, so the timeout only fires without one
    assign tmo_hit = (state_q == WAIT) && !ack_vld &&
                     (wait_cnt_q == 32'(TIMEOUT_CYCLES - 1));

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_q == IDLE) begin
            wait_cnt_d = '0;
        end else if (!done) begin
            wait_cnt_d = wait_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge fsm_clk) begin
        if (fsm_rst) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    assign done = (state_q == WAIT) && (ack_vld || tmo_hit);

    // State register
    always_ff @(posedge fsm_clk) begin
        if (fsm_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_vld) state_d = WAIT;
            WAIT:    if (done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next-state logic
    always_comb begin
        // OR-ing is enough: a pulse on an already-pending master changes nothing
        pending_d  = pending_q | m_req_vld;
        req_vld_d  = 1'b0;
        wr_en_d    = wr_en_q;
        rd_en_d    = rd_en_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        ack_d      = '0;
        rdata_d    = rdata_q;
        tmo_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_vld) begin
                    req_vld_d  = 1'b1;
                    wr_en_d    = buf_wr_q[winner];
                    rd_en_d    = buf_rd_q[winner];
                    addr_d     = buf_addr_q[winner];
                    wdata_d    = buf_wdata_q[winner];
                    gnt_d      = winner;
                    last_gnt_d = winner;
                end
            end
            WAIT: begin
                if (done) begin
                    // Clearing here also drops a same-cycle re-request from the winner
                    pending_d[gnt_q] = 1'b0;
                    ack_d[gnt_q]     = 1'b1;
                    rdata_d          = ack_vld ? rd_data : DATA_WIDTH'(ARB_TIMEOUT_RDATA);
                    tmo_d            = tmo_hit;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge fsm_clk) begin
        if (fsm_rst) begin
            pending_q  <= '0;
            buf_wr_q   <= '0;
            buf_rd_q   <= '0;
            for (int i = 0; i < NUM_MST; i++) begin
                buf_addr_q[i]  <= '0;
                buf_wdata_q[i] <= '0;
            end
            last_gnt_q <= GID_W'(NUM_MST - 1);
            gnt_q      <= '0;
            req_vld_q  <= 1'b0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ack_q      <= '0;
            rdata_q    <= '0;
            tmo_q      <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_MST; i++) begin
                if (m_req_vld[i] && !pending_q[i]) begin
                    buf_wr_q[i]    <= m_wr_en[i];
                    buf_rd_q[i]    <= m_rd_en[i];
                    buf_addr_q[i]  <= m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                    buf_wdata_q[i] <= m_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            pending_q  <= pending_d;
            last_gnt_q <= last_gnt_d;
            gnt_q      <= gnt_d;
            req_vld_q  <= req_vld_d;
            wr_en_q    <= wr_en_d;
            rd_en_q    <= rd_en_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            tmo_q      <= tmo_d;
        end
    end

    assign req_vld   = req_vld_q;
    assign wr_en     = wr_en_q;
    assign rd_en     = rd_en_q;
    assign addr      = addr_q;
    assign wr_data   = wdata_q;
    assign m_ack_vld = ack_q;
    assign m_rd_data = rdata_q;
    assign grant_id  = gnt_q;
    assign timeout   = tmo_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_reg_native_arb.sv
// tb_reg_native_arb: self-checking bench for reg_native_arb (two masters).
// Directed vector table, hand-written multi-cycle sequences, then randomized traffic
// against a transaction-level reference model.
module tb_reg_native_arb;

    localparam int NM  = 2;
    localparam int AW  = 64;
    localparam int DW  = 32;
    localparam int TMO = 16;

    logic             fsm_clk = 1'b0;
    logic             fsm_rst;
    logic [NM-1:0]    m_req_vld, m_wr_en, m_rd_en;
    logic [NM*AW-1:0] m_addr;
    logic [NM*DW-1:0] m_wr_data;
    logic [NM-1:0]    m_ack_vld;
    logic [DW-1:0]    m_rd_data;
    logic             req_vld, wr_en, rd_en;
    logic [AW-1:0]    addr;
    logic [DW-1:0]    wr_data;
    logic             ack_vld;
    logic [DW-1:0]    rd_data;
    logic             busy;
    logic [0:0]       grant_id;
    logic             timeout;

    int checks = 0;
    int errors = 0;

    always #5 fsm_clk = ~fsm_clk;

    reg_native_arb #(
        .NUM_MST       (NM),
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .fsm_clk  (fsm_clk),
        .fsm_rst  (fsm_rst),
        .m_req_vld(m_req_vld),
        .m_wr_en  (m_wr_en),
        .m_rd_en  (m_rd_en),
        .m_addr   (m_addr),
        .m_wr_data(m_wr_data),
        .m_ack_vld(m_ack_vld),
        .m_rd_data(m_rd_data),
        .req_vld  (req_vld),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .addr     (addr),
        .wr_data  (wr_data),
        .ack_vld  (ack_vld),
        .rd_data  (rd_data),
        .busy     (busy),
        .grant_id (grant_id),
        .timeout  (timeout)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Inputs are driven and outputs sampled just after the falling edge
    task automatic cyc();
        @(negedge fsm_clk);
    endtask

    task automatic drive_req(input int m, input bit wr, input bit rd,
                             input logic [63:0] a, input logic [31:0] d);
        m_req_vld[m]         = 1'b1;
        m_wr_en[m]           = wr;
        m_rd_en[m]           = rd;
        m_addr[m*AW +: AW]   = a;
        m_wr_data[m*DW +: DW] = d;
    endtask

    typedef struct {
        int          mst;
        bit          wr;
        logic [63:0] a;
        logic [31:0] d;
        int          lat;
        logic [31:0] rdat;
    } vec_t;

    vec_t vt[4];

    initial begin
        int seen;
        int n;
        int order[$];
        int issued[NM];

        vt[0] = '{0, 1'b1, 64'h0, 32'h1234_5678, 3, 32'h0000_0000};
        vt[1] = '{1, 1'b0, 64'h4, 32'h0, 2, 32'hA5A5_0001};
        vt[2] = '{0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0, 0, 32'h5A5A_FFFF};
        vt[3] = '{1, 1'b1, 64'h8000_0000_0000_0010, 32'hDEAD_BEEF, 5, 32'h1111_2222};

        fsm_rst   = 1'b1;
        m_req_vld = '0;
        m_wr_en   = '0;
        m_rd_en   = '0;
        m_addr    = '0;
        m_wr_data = '0;
        ack_vld   = 1'b0;
        rd_data   = '0;
        cyc();
        cyc();

        // Reset state
        chk("rst_req_vld", req_vld, 0);
        chk("rst_m_ack", m_ack_vld, 0);
        chk("rst_m_rd_data", m_rd_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_addr", addr, 0);
        chk("rst_wr_data", wr_data, 0);
        fsm_rst = 1'b0;

        // Directed single transactions from the vector table
        for (int v = 0; v < 4; v++) begin
            m_addr    = {$urandom, $urandom, $urandom, $urandom};
            m_wr_data = {$urandom, $urandom};
            drive_req(vt[v].mst, vt[v].wr, !vt[v].wr, vt[v].a, vt[v].d);
            cyc();
            chk("tbl_req_early", req_vld, 0);
            m_req_vld = '0;
            cyc();
            chk("tbl_req_vld", req_vld, 1);
            chk("tbl_addr", addr, vt[v].a);
            chk("tbl_wr_data", wr_data, 64'(vt[v].d));
            chk("tbl_wr_rd", {wr_en, rd_en}, {vt[v].wr, !vt[v].wr});
            chk("tbl_grant_id", grant_id, 64'(vt[v].mst));
            chk("tbl_busy", busy, 1);
            for (int k = 0; k < vt[v].lat; k++) begin
                cyc();
                chk("tbl_req_pulse", req_vld, 0);
                chk("tbl_addr_hold", addr, vt[v].a);
                chk("tbl_no_early_ack", m_ack_vld, 0);
            end
            ack_vld = 1'b1;
            rd_data = vt[v].rdat;
            cyc();
            chk("tbl_m_ack", m_ack_vld, 64'(1 << vt[v].mst));
            chk("tbl_m_rd_data", m_rd_data, 64'(vt[v].rdat));
            chk("tbl_busy_done", busy, 0);
            ack_vld = 1'b0;
            rd_data = $urandom;
            cyc();
            chk("tbl_ack_pulse", m_ack_vld, 0);
            chk("tbl_rd_hold", m_rd_data, 64'(vt[v].rdat));
        end

        // Round-robin fairness: both request together, each re-requests on its ack
        order     = {};
        issued[0] = 1;
        issued[1] = 1;
        drive_req(0, 1'b1, 1'b0, 64'h100, 32'h100);
        drive_req(1, 1'b0, 1'b1, 64'h200, 32'h200);
        for (int c = 0; c < 60; c++) begin
            cyc();
            m_req_vld = '0;
            ack_vld   = 1'b0;
            if (req_vld) begin
                order.push_back(int'(grant_id));
                ack_vld = 1'b1;
                rd_data = $urandom;
            end
            for (int i = 0; i < NM; i++) begin
                if (m_ack_vld[i] && issued[i] < 4) begin
                    drive_req(i, 1'b1, 1'b0, 64'(32'h100 * (i + 1)), 32'h0);
                    issued[i]++;
                end
            end
        end
        ack_vld   = 1'b0;
        m_req_vld = '0;
        chk("rr_count", 64'(order.size()), 8);
        for (int i = 0; i < order.size() && i < 8; i++) begin
            chk("rr_order", 64'(order[i]), 64'(i % 2));
        end

        // Drop while pending, capture of another master during WAIT, same-cycle ack drop
        cyc();
        drive_req(0, 1'b1, 1'b0, 64'h8, 32'h88);
        cyc();
        chk("drop_req_early", req_vld, 0);
        drive_req(0, 1'b1, 1'b0, 64'hC, 32'hCC);
        cyc();
        chk("drop_req_vld", req_vld, 1);
        chk("drop_addr_first", addr, 64'h8);
        chk("drop_grant0", grant_id, 0);
        m_req_vld = '0;
        drive_req(1, 1'b0, 1'b1, 64'h20, 32'h0);
        cyc();
        m_req_vld = '0;
        cyc();
        ack_vld = 1'b1;
        rd_data = 32'h0000_0088;
        cyc();
        ack_vld = 1'b0;
        chk("drop_ack0", m_ack_vld, 2'b01);
        cyc();
        chk("ovl_req_vld", req_vld, 1);
        chk("ovl_grant1", grant_id, 1);
        chk("ovl_addr", addr, 64'h20);
        ack_vld = 1'b1;
        rd_data = 32'hBEEF_0020;
        drive_req(1, 1'b0, 1'b1, 64'h30, 32'h0);
        cyc();
        ack_vld   = 1'b0;
        m_req_vld = '0;
        chk("ovl_ack1", m_ack_vld, 2'b10);
        chk("ovl_rd_data", m_rd_data, 32'hBEEF_0020);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            cyc();
            if (req_vld) seen++;
        end
        chk("drop_no_extra_req", 64'(seen), 0);

        // Reset while waiting; the late ack must be ignored and pending must be gone
        drive_req(0, 1'b1, 1'b0, 64'h40, 32'h4040);
        cyc();
        m_req_vld = '0;
        cyc();
        chk("rstw_req_vld", req_vld, 1);
        chk("rstw_grant0", grant_id, 0);
        drive_req(1, 1'b0, 1'b1, 64'h50, 32'h0);
        cyc();
        m_req_vld = '0;
        fsm_rst   = 1'b1;
        cyc();
        chk("rstw_busy", busy, 0);
        chk("rstw_m_ack", m_ack_vld, 0);
        chk("rstw_grant_id", grant_id, 0);
        chk("rstw_m_rd_data", m_rd_data, 0);
        fsm_rst = 1'b0;
        ack_vld = 1'b1;
        rd_data = 32'h7777_7777;
        cyc();
        ack_vld = 1'b0;
        chk("rstw_late_ack", m_ack_vld, 0);
        chk("rstw_rd_kept", m_rd_data, 0);
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            cyc();
            if (req_vld) seen++;
        end
        chk("rstw_pending_clr", 64'(seen), 0);
        drive_req(0, 1'b1, 1'b0, 64'h60, 32'h6060);
        drive_req(1, 1'b1, 1'b0, 64'h70, 32'h7070);
        cyc();
        m_req_vld = '0;
        cyc();
        chk("rstw_first_grant", grant_id, 0);
        chk("rstw_first_addr", addr, 64'h60);
        ack_vld = 1'b1;
        cyc();
        ack_vld = 1'b0;
        cyc();
        chk("rstw_second_req", req_vld, 1);
        chk("rstw_second_grant", grant_id, 1);
        chk("rstw_second_addr", addr, 64'h70);
        ack_vld = 1'b1;
        cyc();
        ack_vld = 1'b0;
        cyc();

`ifdef REG_NATIVE_ARB_TIMEOUT_EN
        // Slave never answers: the arbiter completes the transaction itself
        drive_req(0, 1'b0, 1'b1, 64'h80, 32'h0);
        cyc();
        m_req_vld = '0;
        cyc();
        chk("tmo_req_vld", req_vld, 1);
        n = -1;
        for (int c = 1; c <= 40; c++) begin
            cyc();
            if (m_ack_vld != '0 && n < 0) begin
                n = c;
                chk("tmo_pulse", timeout, 1);
                chk("tmo_m_ack", m_ack_vld, 2'b01);
                chk("tmo_rd_data", m_rd_data, 32'hDEAD_DEAD);
            end
            if (n > 0 && c == n + 1) begin
                chk("tmo_pulse_end", timeout, 0);
                chk("tmo_busy", busy, 0);
            end
        end
        chk("tmo_cycles", 64'(n), 64'(TMO));
`endif

        // Randomized traffic against a transaction-level reference model
        begin : rnd
            bit [NM-1:0] pend, pend_pre;
            logic [63:0] baddr[NM];
            logic [31:0] bwd[NM];
            bit          bwr[NM], brd[NM];
            bit          outst, sl_act, e_req, e_wr, e_rd;
            int          g, last, w, sl_cnt, e_gid;
            logic [NM-1:0] e_ack;
            logic [63:0] e_addr;
            logic [31:0] e_wd, e_rdat;

            fsm_rst   = 1'b1;
            m_req_vld = '0;
            ack_vld   = 1'b0;
            cyc();
            fsm_rst = 1'b0;
            pend    = '0;
            outst   = 1'b0;
            sl_act  = 1'b0;
            sl_cnt  = 0;
            g       = 0;
            last    = NM - 1;
            e_gid   = 0;
            e_addr  = '0;
            e_wd    = '0;
            e_wr    = 1'b0;
            e_rd    = 1'b0;
            e_rdat  = '0;
            for (int i = 0; i < NM; i++) begin
                baddr[i] = '0;
                bwd[i]   = '0;
                bwr[i]   = 1'b0;
                brd[i]   = 1'b0;
            end

            for (int c = 0; c < 1500; c++) begin
                cyc();
                // Apply the rules for the edge that just consumed the driven inputs
                pend_pre = pend;
                e_req    = 1'b0;
                e_ack    = '0;
                if (outst) begin
                    if (ack_vld) begin
                        e_ack[g] = 1'b1;
                        e_rdat   = rd_data;
                        pend[g]  = 1'b0;
                        outst    = 1'b0;
                    end
                end else begin
                    w = -1;
                    for (int k = 1; k <= NM; k++) begin
                        if (w < 0 && pend_pre[(last + k) % NM]) w = (last + k) % NM;
                    end
                    if (w >= 0) begin
                        e_req  = 1'b1;
                        g      = w;
                        last   = w;
                        outst  = 1'b1;
                        e_gid  = w;
                        e_addr = baddr[w];
                        e_wd   = bwd[w];
                        e_wr   = bwr[w];
                        e_rd   = brd[w];
                    end
                end
                for (int i = 0; i < NM; i++) begin
                    if (m_req_vld[i] && !pend_pre[i]) begin
                        pend[i]  = 1'b1;
                        baddr[i] = m_addr[i*AW +: AW];
                        bwd[i]   = m_wr_data[i*DW +: DW];
                        bwr[i]   = m_wr_en[i];
                        brd[i]   = m_rd_en[i];
                    end
                end

                chk("rnd_req_vld", req_vld, e_req);
                chk("rnd_m_ack", m_ack_vld, e_ack);
                chk("rnd_busy", busy, outst);
                chk("rnd_grant_id", grant_id, 64'(e_gid));
                chk("rnd_m_rd_data", m_rd_data, e_rdat);
                chk("rnd_addr", addr, e_addr);
                chk("rnd_wr_data", wr_data, e_wd);
                chk("rnd_wr_rd", {wr_en, rd_en}, {e_wr, e_rd});
                chk("rnd_timeout", timeout, 0);

                // New stimulus for the next edge
                m_req_vld = '0;
                ack_vld   = 1'b0;
                for (int i = 0; i < NM; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        drive_req(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                  {$urandom, $urandom}, $urandom);
                    end
                end
                if (req_vld) begin
                    sl_act = 1'b1;
                    sl_cnt = int'($urandom_range(0, 4));
                end
                if (sl_act) begin
                    if (sl_cnt == 0) begin
                        ack_vld = 1'b1;
                        rd_data = $urandom;
                        sl_act  = 1'b0;
                    end else begin
                        sl_cnt--;
                    end
                end else if ($urandom_range(0, 7) == 0) begin
                    // Stray ack while nothing is outstanding downstream
                    ack_vld = 1'b1;
                    rd_data = $urandom;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
